gb_joypad: RTL and testbench

Converts the decoded PlayStation pad state from `pad_driver` into the Game Boy P1/JOYP register (FF00), joypad interrupt and rumble drive. It sits directly downstream of `pad_driver` for keys and sticks, and directly upstream of it for the `vibrate`/`vibrate_sub` motor commands. The CPU bus reads and writes P1 through this block.

---
 rtl/gb_joypad.sv | 103 ++++++++++
 tb/tb_gb_joypad.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gb_joypad.sv
// gb_joypad: maps PlayStation pad state onto the Game Boy P1/JOYP register, joypad IRQ and rumble drive.
// Keys are registered with turbo, stick hysteresis and opposite-direction suppression applied.
module gb_joypad #(
    parameter int          TURBO_FRAMES = 3,
    parameter logic [7:0]  STICK_ON     = 8'h40,
    parameter logic [7:0]  STICK_OFF    = 8'h20,
    parameter logic [7:0]  RUMBLE_LEVEL = 8'hC0,
    parameter int          RUMBLE_HOLD  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        pad_connect,
    input  logic [15:0] pad_buttons,
    input  logic [7:0]  pad_left_hori,
    input  logic [7:0]  pad_left_vert,
    input  logic        p1_wr,
    input  logic [7:0]  p1_wdata,
    output logic [7:0]  p1_rdata,
    output logic        joy_irq,
    input  logic        rumble_on,
    output logic [7:0]  vibrate,
    output logic        vibrate_sub
);
    localparam logic [7:0] LO_ON  = 8'h80 - STICK_ON;
    localparam logic [7:0] LO_OFF = 8'h80 - STICK_OFF;
    localparam logic [7:0] HI_ON  = 8'h80 + STICK_ON;
    localparam logic [7:0] HI_OFF = 8'h80 + STICK_OFF;
    localparam logic [3:0] T_LAST = 4'(TURBO_FRAMES - 1);
    localparam logic [3:0] HOLD   = 4'(RUMBLE_HOLD);

    logic [15:0] prs;
    logic [3:0]  stick_q, stick_d;
    logic [7:0]  keys_q, keys_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic        tph_q, tph_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  nib, nib_q;
    logic        irq_q, rum_q;
    logic [3:0]  hold_q, hold_d;
    logic [7:0]  vib_q, vib_d;
    logic        r, l, u, d, held;
    logic        unused_ok;

    function automatic logic hyst(input logic q, input logic set, input logic clr);
        return q ? ~clr : set;
    endfunction

    // stick_* and keys_* direction order: {D, U, L, R}
    always_comb begin
        prs     = ~pad_buttons;
        stick_d = pad_connect ? {hyst(stick_q[3], pad_left_vert >= HI_ON, pad_left_vert < HI_OFF),
                                 hyst(stick_q[2], pad_left_vert <= LO_ON, pad_left_vert > LO_OFF),
                                 hyst(stick_q[1], pad_left_hori <= LO_ON, pad_left_hori > LO_OFF),
                                 hyst(stick_q[0], pad_left_hori >= HI_ON, pad_left_hori < HI_OFF)} : 4'h0;
        r       = prs[5] | stick_d[0];
        l       = prs[7] | stick_d[1];
        u       = prs[4] | stick_d[2];
        d       = prs[6] | stick_d[3];
        keys_d  = pad_connect ? {d & ~u, u & ~d, l & ~r, r & ~l, prs[3], prs[0],
                                 prs[14] | (prs[15] & tph_q), prs[13] | (prs[12] & tph_q)} : 8'h00;
        held    = pad_connect & (prs[12] | prs[15]);
        tcnt_d  = !held ? 4'd0 : !frame_tick ? tcnt_q : (tcnt_q == T_LAST) ? 4'd0 : tcnt_q + 4'd1;
        tph_d   = !held ? 1'b1 : (frame_tick && tcnt_q == T_LAST) ? ~tph_q : tph_q;
        sel_d   = p1_wr ? p1_wdata[5:4] : sel_q;
        nib     = (sel_q[0] ? 4'hF : ~keys_q[7:4]) & (sel_q[1] ? 4'hF : ~keys_q[3:0]);
        hold_d  = !pad_connect ? 4'd0 : (rumble_on && !rum_q) ? HOLD :
                  (frame_tick && hold_q != 4'd0) ? hold_q - 4'd1 : hold_q;
        vib_d   = (pad_connect && (rum_q || hold_q != 4'd0)) ? RUMBLE_LEVEL : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stick_q <= 4'h0;
            keys_q  <= 8'h00;
            tcnt_q  <= 4'd0;
            tph_q   <= 1'b1;
            sel_q   <= 2'b11;
            nib_q   <= 4'hF;
            irq_q   <= 1'b0;
            rum_q   <= 1'b0;
            hold_q  <= 4'd0;
            vib_q   <= 8'h00;
        end else begin
            stick_q <= stick_d;
            keys_q  <= keys_d;
            tcnt_q  <= tcnt_d;
            tph_q   <= tph_d;
            sel_q   <= sel_d;
            nib_q   <= nib;
            irq_q   <= |(nib_q & ~nib);
            rum_q   <= rumble_on;
            hold_q  <= hold_d;
            vib_q   <= vib_d;
        end
    end

    assign p1_rdata    = {2'b11, sel_q, nib};
    assign joy_irq     = irq_q;
    assign vibrate     = vib_q;
    assign vibrate_sub = 1'b0;
    assign unused_ok   = ^{pad_buttons[11:8], pad_buttons[2:1], p1_wdata[7:6], p1_wdata[3:0]};
endmodule

// File: tb/tb_gb_joypad.sv
// tb_gb_joypad: directed bench for gb_joypad with hand-computed P1, IRQ and rumble expectations.
module tb_gb_joypad;
    logic        clk = 0, reset = 1, frame_tick = 0, pad_connect = 1, p1_wr = 0, rumble_on = 0;
    logic [15:0] pad_buttons = 16'hFFFF;
    logic [7:0]  pad_left_hori = 8'h80, pad_left_vert = 8'h80, p1_wdata = 8'h00;
    logic [7:0]  p1_rdata, vibrate;
    logic        joy_irq, vibrate_sub;
    int          n_chk = 0, n_fail = 0;

    gb_joypad dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .pad_connect(pad_connect),
        .pad_buttons(pad_buttons), .pad_left_hori(pad_left_hori), .pad_left_vert(pad_left_vert),
        .p1_wr(p1_wr), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .joy_irq(joy_irq),
        .rumble_on(rumble_on), .vibrate(vibrate), .vibrate_sub(vibrate_sub)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] v);
        p1_wr = 1; p1_wdata = v;
        step(1);
        p1_wr = 0;
    endtask

    task automatic tick();
        frame_tick = 1;
        step(1);
        frame_tick = 0;
        step(9);
    endtask

    initial begin
        step(3);
        chk("reset_p1", p1_rdata, 8'hFF);
        chk("reset_irq", {7'd0, joy_irq}, 8'h00);
        chk("reset_vib", vibrate, 8'h00);
        chk("reset_vsub", {7'd0, vibrate_sub}, 8'h00);
        reset = 0;
        // button read
        wr(8'h10);
        chk("btn_sel", p1_rdata, 8'hDF);
        pad_buttons[13] = 0;
        step(1);
        chk("btn_press", p1_rdata, 8'hDE);
        chk("btn_irq_early", {7'd0, joy_irq}, 8'h00);
        step(1);
        chk("btn_irq", {7'd0, joy_irq}, 8'h01);
        chk("btn_hold", p1_rdata, 8'hDE);
        step(1);
        chk("btn_irq_once", {7'd0, joy_irq}, 8'h00);
        pad_buttons = 16'hFFFF;
        step(1);
        chk("btn_release", p1_rdata, 8'hDF);
        step(1);
        chk("btn_rel_irq", {7'd0, joy_irq}, 8'h00);
        step(1);
        chk("btn_rel_irq2", {7'd0, joy_irq}, 8'h00);
        // stick hysteresis on the left direction
        wr(8'h20);
        chk("dpad_sel", p1_rdata, 8'hEF);
        pad_left_hori = 8'h3F;
        step(1);
        chk("stick_left", p1_rdata, 8'hED);
        step(1);
        chk("stick_irq", {7'd0, joy_irq}, 8'h01);
        pad_left_hori = 8'h58;
        step(2);
        chk("stick_hold", p1_rdata, 8'hED);
        pad_left_hori = 8'h61;
        step(1);
        chk("stick_release", p1_rdata, 8'hEF);
        // opposite directions cancel
        pad_left_hori = 8'hC0;
        pad_buttons[7] = 0;
        step(1);
        chk("opp_nib", p1_rdata, 8'hEF);
        step(1);
        chk("opp_irq", {7'd0, joy_irq}, 8'h00);
        step(1);
        chk("opp_irq2", {7'd0, joy_irq}, 8'h00);
        pad_left_hori = 8'h80;
        step(1);
        chk("dpad_left", p1_rdata, 8'hED);
        pad_left_vert = 8'h20;
        step(1);
        chk("left_up", p1_rdata, 8'hE9);
        pad_buttons = 16'hFFFF;
        pad_left_vert = 8'h80;
        step(2);
        chk("dirs_clear", p1_rdata, 8'hEF);
        // turbo on triangle
        wr(8'h10);
        pad_buttons[12] = 0;
        step(1);
        chk("turbo_first", p1_rdata, 8'hDE);
        tick(); tick();
        chk("turbo_2ticks", p1_rdata, 8'hDE);
        tick();
        chk("turbo_off", p1_rdata, 8'hDF);
        tick(); tick(); tick();
        chk("turbo_on", p1_rdata, 8'hDE);
        tick(); tick(); tick();
        chk("turbo_off2", p1_rdata, 8'hDF);
        pad_buttons = 16'hFFFF;
        step(2);
        chk("turbo_release", p1_rdata, 8'hDF);
        pad_buttons[12] = 0;
        step(1);
        chk("turbo_phase_reset", p1_rdata, 8'hDE);
        pad_buttons = 16'hFFFF;
        step(2);
        // rumble pulse with hold
        rumble_on = 1;
        step(1);
        rumble_on = 0;
        chk("rumble_lat", vibrate, 8'h00);
        step(1);
        chk("rumble_on", vibrate, 8'hC0);
        tick(); tick(); tick();
        chk("rumble_hold3", vibrate, 8'hC0);
        tick();
        chk("rumble_end", vibrate, 8'h00);
        // disconnect mid-rumble with keys held
        pad_buttons[13] = 0;
        rumble_on = 1;
        step(3);
        chk("conn_vib", vibrate, 8'hC0);
        chk("conn_p1", p1_rdata, 8'hDE);
        pad_connect = 0;
        step(1);
        chk("disc_vib", vibrate, 8'h00);
        chk("disc_p1", p1_rdata, 8'hDF);
        pad_connect = 1;
        rumble_on = 0;
        pad_buttons = 16'hFFFF;
        step(2);
        // reset overrides a concurrent write
        reset = 1; p1_wr = 1; p1_wdata = 8'h00;
        step(1);
        p1_wr = 0;
        chk("reset_over_wr", p1_rdata, 8'hFF);
        reset = 0;
        step(1);
        chk("post_reset", p1_rdata, 8'hFF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
